// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the two-requester FIFO write arbiter.
// Both the arbiter top and its occupancy counter import this package.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_BURST = 4;

endpackage

// File: rtl/fifo_occ_counter.sv
// Tracks FIFO occupancy from the write/read enable mirrors; count saturates at 0..DEPTH.
// Latency: count/full/empty update on the edge of the accepted write or read.
// Backpressure: none here; full is consumed by the arbiter to block grants.
module fifo_occ_counter
    import fifo_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic                     ren,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

    logic [CW-1:0] count_q;

    assign count = count_q;
    assign full  = (count_q == DEPTH_L);
    assign empty = (count_q == '0);

    // A simultaneous write and read cancels; a read while empty is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (wen && !ren && !full) begin
            count_q <= count_q + CW'(1);
        end else if (ren && !wen && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with bounded bursts granting two requesters into one FIFO write port.
// Latency: grant is combinational; a beat is written on the same edge it is granted.
// Backpressure: full blocks every grant; requesters hold req and data until granted.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BURST = DEF_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [WIDTH-1:0]         data0,
    input  logic [WIDTH-1:0]         data1,
    output logic                     gnt0,
    output logic                     gnt1,
    input  logic                     fifo_ren,
    output logic                     fifo_wen,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_L = BW'(BURST);

    arb_state_t    state;
    logic [BW-1:0] beats;
    logic          last;

    logic own0_cont;
    logic own1_cont;
    logic owner_cont;
    logic win_vld;
    logic win_idx;
    logic xfer;

    assign own0_cont  = (state == OWN0) && req0 && (beats < BURST_L);
    assign own1_cont  = (state == OWN1) && req1 && (beats < BURST_L);
    assign owner_cont = own0_cont || own1_cont;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 1'b0;
        if (own0_cont) begin
            win_vld = 1'b1;
            win_idx = 1'b0;
        end else if (own1_cont) begin
            win_vld = 1'b1;
            win_idx = 1'b1;
        end else if (req0 && req1) begin
            win_vld = 1'b1;
            win_idx = ~last;
        end else if (req0) begin
            win_vld = 1'b1;
            win_idx = 1'b0;
        end else if (req1) begin
            win_vld = 1'b1;
            win_idx = 1'b1;
        end
    end

    // rst gates the grants directly so a mid-burst reset drops them without a clock.
    assign gnt0       = win_vld && !win_idx && !full && !rst;
    assign gnt1       = win_vld &&  win_idx && !full && !rst;
    assign xfer       = gnt0 || gnt1;
    assign fifo_wen   = xfer;
    assign fifo_wdata = gnt1 ? data1 : data0;

    // An owner that wins again after exhausting its burst re-acquires with beats = 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beats <= '0;
            last  <= 1'b1;
        end else if (xfer) begin
            if (owner_cont) begin
                beats <= beats + BW'(1);
            end else begin
                state <= win_idx ? OWN1 : OWN0;
                beats <= BW'(1);
                last  <= win_idx;
            end
        end else if (!full) begin
            if ((state == OWN0 && !req0) || (state == OWN1 && !req1)) begin
                state <= IDLE;
                beats <= '0;
            end
        end
    end

    fifo_occ_counter #(
        .DEPTH (DEPTH)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .wen   (fifo_wen),
        .ren   (fifo_ren),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of requester and FIFO write data.
REQ-002 Parameter DEPTH, default 16, FIFO capacity in entries; a power of two, at least 2.
REQ-003 Parameter BURST, default 4, maximum consecutive beats per ownership; at least 1.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req0, req1  input  1 each  write request from requester 0 or 1; held with data until granted.
REQ-007 Port data0, data1  input  WIDTH each  write data from requester 0 or 1.
REQ-008 Port gnt0, gnt1  output  1 each  combinational grant; a beat transfers when reqN and gntN are both high at a clk edge.
REQ-009 Port fifo_ren  input  1  mirror of the FIFO read enable, used for occupancy tracking.
REQ-010 Port fifo_wen  output  1  FIFO write enable; equals gnt0 | gnt1.
REQ-011 Port fifo_wdata  output  WIDTH  data of the granted requester; data0 when no grant.
REQ-012 Port count  output  clog2(DEPTH)+1  current FIFO occupancy, range 0..DEPTH.
REQ-013 Port full, empty  output  1 each  full = (count == DEPTH); empty = (count == 0).

Function
REQ-014 FSM states: IDLE, OWN0, OWN1. Registers: beats (0..BURST) and last (index of the most recent winner).
REQ-015 Owner-continue rule: in OWNi with reqi high and beats < BURST, the winner is i.
REQ-016 Otherwise the winner is selected by round-robin.
- Both requesters asserting: winner = index != last.
- One requester asserting: that requester wins.
- No requester asserting: no winner.
REQ-017 Grant gating: gnti = (winner == i) & ~full & ~rst; at most one grant is high in any cycle.
REQ-018 Full blocks all grants, even when fifo_ren is high in the same cycle.
REQ-019 Transfer by the current owner: beats increments by 1; state is unchanged.
REQ-020 Transfer by a requester that is not the current owner: state becomes OWNw, beats = 1, last = w.
REQ-021 No transfer, in OWNi with reqi low: state becomes IDLE and beats = 0.
REQ-022 No transfer with full high: state, beats and last hold.
REQ-023 Release is bubble-free: when OWNi ends (beats == BURST, or reqi low), the other requester may be granted in that same cycle.
REQ-024 Occupancy update per edge:
- +1 on fifo_wen & ~fifo_ren.
- -1 on fifo_ren & ~fifo_wen & ~empty.
- Unchanged on simultaneous write and read.
- Unchanged on a read while empty.
REQ-025 count never exceeds DEPTH and never wraps below 0.
REQ-026 All outputs are registered state or combinational logic of registered state and inputs; no latency beyond the transfer edge.

Reset
REQ-027 While rst is high: state = IDLE, beats = 0, last = 1 (so requester 0 wins first), count = 0, empty = 1, full = 0, gnt0 = gnt1 = fifo_wen = 0.
REQ-028 Reset asserted mid-burst forces the grants low immediately, without waiting for clk.
REQ-029 After rst deasserts, arbitration resumes on the next edge from the reset state.

Structure
REQ-030 Shared package fifo_arb_pkg shall hold:
- the state enum {IDLE, OWN0, OWN1};
- default constants WIDTH = 8, DEPTH = 16, BURST = 4.
REQ-031 Occupancy tracking shall be one sub-module, fifo_occ_counter, with ports:
- inputs clk, rst, wen, ren;
- outputs count, full, empty.
REQ-032 Arbitration and the FSM stay in fifo_wr_arbiter.

Verification
REQ-033 Reset, then req0=1 and req1=1 held for 8 cycles -> grants 0,0,0,0,1,1,1,1; count = 8.
REQ-034 req0 only, 20 cycles, fifo_ren=0 -> 16 writes, then full=1, gnt0=0, count=16 holds.
REQ-035 Full with fifo_ren=1 for 1 cycle -> count=15; no grant in the full cycle; gnt0 is high in the next cycle.
REQ-036 OWN0 after 2 beats; req0 drops while req1=1 -> gnt1 in that same cycle; state becomes OWN1 with beats=1.
REQ-037 fifo_wen=1 and fifo_ren=1 with count=5 -> count stays 5; fifo_ren=1 with count=0 -> count stays 0 and empty=1.
REQ-038 rst pulsed mid-burst (OWN1, beats=2) -> gnt1 drops at once; count=0; after release with both requesting, gnt0 is first.
